parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: debounced entry/exit requests, slot command pulses
// to the bookkeeping block, and a timed gate-open window after each command.

module GateDebounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rawLevel_i,
    output logic event_o
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    logic       level;

    assign level = sync_q[1];

    // While armed we count high cycles toward a press; once fired we count
    // low cycles toward re-arming. Starting disarmed means a button held
    // through reset cannot produce an event after release.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        event_o = 1'b0;
        if (level == armed_q) begin
            if (cnt_q == DEB_LAST) begin
                cnt_d   = 8'd0;
                armed_d = ~armed_q;
                event_o = armed_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rawLevel_i};
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

module parking_gate_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_slot_sel,
    input  logic [2:0] car_state,
    output logic       car_enter,
    output logic       car_exit,
    output logic [2:0] car_sel,
    output logic       gate_open,
    output logic       full,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GATE
    } state_t;

    localparam logic [7:0] GATE_LAST = 8'(GATE_CYCLES - 1);

    state_t     state_q;
    logic       pendEntry_q, pendExit_q;
    logic [7:0] gateCnt_q;
    logic       carEnter_q, carExit_q, gateOpen_q, full_q, err_q;
    logic [2:0] carSel_q;

    logic       entryEvent, exitEvent;
    logic       exitOneHot, exitValid, lotFull;
    logic [2:0] freeSlot;

    GateDebounce #(.DEB_CYCLES(DEB_CYCLES)) entryDeb (
        .clk       (clk),
        .reset     (reset),
        .rawLevel_i(entry_req),
        .event_o   (entryEvent)
    );

    GateDebounce #(.DEB_CYCLES(DEB_CYCLES)) exitDeb (
        .clk       (clk),
        .reset     (reset),
        .rawLevel_i(exit_req),
        .event_o   (exitEvent)
    );

    assign exitOneHot = (exit_slot_sel == 3'b001) || (exit_slot_sel == 3'b010) ||
                        (exit_slot_sel == 3'b100);
    assign exitValid  = exitOneHot && ((exit_slot_sel & car_state) != 3'b000);
    assign lotFull    = (car_state == 3'b111);

    always_comb begin
        freeSlot = 3'b000;
        if (!car_state[0])      freeSlot = 3'b001;
        else if (!car_state[1]) freeSlot = 3'b010;
        else if (!car_state[2]) freeSlot = 3'b100;
    end

    // Pending flags set on events; a clear in IDLE service is written later
    // so it wins, dropping an event that collides with its own service.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pendEntry_q <= 1'b0;
            pendExit_q  <= 1'b0;
            gateCnt_q   <= 8'd0;
            carEnter_q  <= 1'b0;
            carExit_q   <= 1'b0;
            carSel_q    <= 3'b000;
            gateOpen_q  <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            carEnter_q  <= 1'b0;
            carExit_q   <= 1'b0;
            carSel_q    <= 3'b000;
            err_q       <= 1'b0;
            full_q      <= lotFull;
            pendEntry_q <= pendEntry_q | entryEvent;
            pendExit_q  <= pendExit_q | exitEvent;
            case (state_q)
                IDLE: begin
                    if (pendExit_q) begin
                        pendExit_q <= 1'b0;
                        if (exitValid) begin
                            carExit_q <= 1'b1;
                            carSel_q  <= exit_slot_sel;
                            state_q   <= CMD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (pendEntry_q) begin
                        pendEntry_q <= 1'b0;
                        if (!lotFull) begin
                            carEnter_q <= 1'b1;
                            carSel_q   <= freeSlot;
                            state_q    <= CMD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    gateOpen_q <= 1'b1;
                    gateCnt_q  <= GATE_LAST;
                    state_q    <= GATE;
                end
                GATE: begin
                    if (gateCnt_q == 8'd0) begin
                        gateOpen_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gateCnt_q <= gateCnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign car_enter = carEnter_q;
    assign car_exit  = carExit_q;
    assign car_sel   = carSel_q;
    assign gate_open = gateOpen_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with the default DEB_CYCLES=4 and
// GATE_CYCLES=8; a negedge monitor tallies pulses that the steps then check.

module tb_parking_gate_ctrl;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot_sel;
    logic [2:0] car_state;
    logic       car_enter;
    logic       car_exit;
    logic [2:0] car_sel;
    logic       gate_open;
    logic       full;
    logic       err;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int enterCnt = 0, exitCnt = 0, errCnt = 0, gateCnt = 0, violCnt = 0;
    int enterCyc = 0, exitCyc = 0;
    logic [2:0] lastEnterSel = 3'b000, lastExitSel = 3'b000;
    int bEnter, bExit, bErr, bGate;

    parking_gate_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .exit_slot_sel(exit_slot_sel),
        .car_state    (car_state),
        .car_enter    (car_enter),
        .car_exit     (car_exit),
        .car_sel      (car_sel),
        .gate_open    (gate_open),
        .full         (full),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor: tallies pulses and flags illegal output combinations.
    always @(negedge clk) begin
        cyc++;
        if (car_enter) begin
            enterCnt++;
            enterCyc = cyc;
            lastEnterSel = car_sel;
        end
        if (car_exit) begin
            exitCnt++;
            exitCyc = cyc;
            lastExitSel = car_sel;
        end
        if (err) errCnt++;
        if (gate_open) gateCnt++;
        if ((car_enter && car_exit) || (!car_enter && !car_exit && car_sel != 3'b000))
            violCnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snapshot();
        bEnter = enterCnt;
        bExit  = exitCnt;
        bErr   = errCnt;
        bGate  = gateCnt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Press the selected buttons for holdCycles, release, then let things settle.
    task automatic applyStimulus(input logic doEntry, input logic doExit,
                                 input int holdCycles, input int settleCycles);
        entry_req = doEntry;
        exit_req  = doExit;
        tick(holdCycles);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick(settleCycles);
    endtask

    initial begin
        reset         = 1'b0;
        entry_req     = 1'b0;
        exit_req      = 1'b0;
        exit_slot_sel = 3'b000;
        car_state     = 3'b000;

        #12;
        checkOutput("reset_outputs",
                    {26'd0, car_enter, car_exit, car_sel, gate_open, full, err}, 32'd0);
        tick(1);
        reset = 1'b1;
        tick(10);

        $display("[TB] single entry into empty lot");
        snapshot();
        entry_req = 1'b1;
        tick(6);
        checkOutput("entry_not_yet", {31'd0, car_enter}, 32'd0);
        tick(1);
        checkOutput("entry_latency", {31'd0, car_enter}, 32'd1);
        checkOutput("entry_sel", {29'd0, car_sel}, 32'd1);
        tick(1);
        checkOutput("cmd_one_cycle", {31'd0, car_enter}, 32'd0);
        checkOutput("gate_starts", {31'd0, gate_open}, 32'd1);
        checkOutput("sel_cleared", {29'd0, car_sel}, 32'd0);
        tick(2);
        entry_req = 1'b0;
        tick(20);
        checkOutput("entry_pulses", enterCnt - bEnter, 32'd1);
        checkOutput("entry_gate_len", gateCnt - bGate, 32'd8);
        checkOutput("entry_no_err", errCnt - bErr, 32'd0);
        checkOutput("entry_no_exit", exitCnt - bExit, 32'd0);

        $display("[TB] entry into full lot");
        car_state = 3'b111;
        tick(2);
        checkOutput("full_flag", {31'd0, full}, 32'd1);
        snapshot();
        applyStimulus(1'b1, 1'b0, 8, 20);
        checkOutput("full_err", errCnt - bErr, 32'd1);
        checkOutput("full_no_enter", enterCnt - bEnter, 32'd0);
        checkOutput("full_no_gate", gateCnt - bGate, 32'd0);

        $display("[TB] exit selections");
        car_state     = 3'b010;
        exit_slot_sel = 3'b010;
        tick(2);
        checkOutput("not_full", {31'd0, full}, 32'd0);
        snapshot();
        applyStimulus(1'b0, 1'b1, 8, 25);
        checkOutput("exit_pulses", exitCnt - bExit, 32'd1);
        checkOutput("exit_sel", {29'd0, lastExitSel}, 32'd2);
        checkOutput("exit_gate_len", gateCnt - bGate, 32'd8);
        checkOutput("exit_no_err", errCnt - bErr, 32'd0);

        exit_slot_sel = 3'b100;
        snapshot();
        applyStimulus(1'b0, 1'b1, 8, 20);
        checkOutput("exit_empty_err", errCnt - bErr, 32'd1);
        checkOutput("exit_empty_nocmd", exitCnt - bExit, 32'd0);
        checkOutput("exit_empty_nogate", gateCnt - bGate, 32'd0);

        exit_slot_sel = 3'b011;
        snapshot();
        applyStimulus(1'b0, 1'b1, 8, 20);
        checkOutput("exit_multi_err", errCnt - bErr, 32'd1);
        checkOutput("exit_multi_nocmd", exitCnt - bExit, 32'd0);

        $display("[TB] simultaneous entry and exit");
        car_state     = 3'b001;
        exit_slot_sel = 3'b001;
        snapshot();
        applyStimulus(1'b1, 1'b1, 8, 35);
        checkOutput("both_exit", exitCnt - bExit, 32'd1);
        checkOutput("both_enter", enterCnt - bEnter, 32'd1);
        checkOutput("both_exit_sel", {29'd0, lastExitSel}, 32'd1);
        checkOutput("both_enter_sel", {29'd0, lastEnterSel}, 32'd2);
        checkOutput("both_order_gap", enterCyc - exitCyc, 32'd10);
        checkOutput("both_gate_len", gateCnt - bGate, 32'd16);

        $display("[TB] glitch and long press");
        car_state = 3'b000;
        snapshot();
        applyStimulus(1'b1, 1'b0, 3, 20);
        checkOutput("glitch_no_enter", enterCnt - bEnter, 32'd0);
        checkOutput("glitch_no_err", errCnt - bErr, 32'd0);
        snapshot();
        applyStimulus(1'b1, 1'b0, 50, 25);
        checkOutput("long_press_once", enterCnt - bEnter, 32'd1);

        $display("[TB] reset during gate");
        entry_req = 1'b1;
        tick(8);
        entry_req = 1'b0;
        checkOutput("gate_first", {31'd0, gate_open}, 32'd1);
        tick(3);
        checkOutput("gate_fourth", {31'd0, gate_open}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {26'd0, car_enter, car_exit, car_sel, gate_open, full, err}, 32'd0);
        tick(2);
        reset = 1'b1;
        snapshot();
        tick(30);
        checkOutput("post_reset_no_enter", enterCnt - bEnter, 32'd0);
        checkOutput("post_reset_no_gate", gateCnt - bGate, 32'd0);
        checkOutput("post_reset_no_err", errCnt - bErr, 32'd0);
        snapshot();
        applyStimulus(1'b1, 1'b0, 8, 25);
        checkOutput("post_reset_press", enterCnt - bEnter, 32'd1);
        checkOutput("post_reset_gate", gateCnt - bGate, 32'd8);

        checkOutput("never_both_or_stray_sel", violCnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
